// File: rtl/rv_burst_source.sv
// rv_burst_source: ready/valid burst transmitter.
// Accepts one command (base, step, len) and emits len beats forming the arithmetic
// sequence base, base+step, ... on a ready/valid stream, honouring backpressure.
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready is decoded from state only
//   cmd_base/step/len     burst description; len==0 is an empty burst
//   out_valid/out_ready   beat handshake
//   out_data, out_last    beat value and final-beat flag
//   busy                  burst in progress
//   done                  one-cycle pulse when a burst (including empty) completes
module rv_burst_source #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_base,
    input  logic [DATA_WIDTH-1:0] cmd_step,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] step_q;
    logic [DATA_WIDTH-1:0] step_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [LEN_WIDTH-1:0]  remaining_nxt;
    logic                  valid_nxt;
    logic                  last_nxt;
    logic                  done_nxt;

    // Only output not registered; depends on state alone, so no input-to-output path.
    assign cmd_ready = (state == IDLE);

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            step_q    <= '0;
            remaining <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            step_q    <= step_nxt;
            remaining <= remaining_nxt;
            out_valid <= valid_nxt;
            out_data  <= data_nxt;
            out_last  <= last_nxt;
            busy      <= (state_nxt == SEND);
            done      <= done_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nxt     = state;
        step_nxt      = step_q;
        remaining_nxt = remaining;
        valid_nxt     = out_valid;
        data_nxt      = out_data;
        last_nxt      = out_last;
        done_nxt      = 1'b0;

        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
                if (cmd_valid) begin
                    if (cmd_len != '0) begin
                        state_nxt     = SEND;
                        step_nxt      = cmd_step;
                        remaining_nxt = cmd_len;
                        valid_nxt     = 1'b1;
                        data_nxt      = cmd_base;
                        last_nxt      = (cmd_len == LEN_WIDTH'(1));
                    end else begin
                        // Empty burst: acknowledged with a done pulse, no beats.
                        done_nxt = 1'b1;
                    end
                end
            end
            SEND: begin
                valid_nxt = 1'b1;
                if (out_ready) begin
                    if (remaining > LEN_WIDTH'(1)) begin
                        // Addition wraps modulo 2**DATA_WIDTH by truncation.
                        data_nxt      = DATA_WIDTH'(out_data + step_q);
                        remaining_nxt = LEN_WIDTH'(remaining - LEN_WIDTH'(1));
                        last_nxt      = (remaining == LEN_WIDTH'(2));
                    end else begin
                        state_nxt     = IDLE;
                        remaining_nxt = '0;
                        valid_nxt     = 1'b0;
                        last_nxt      = 1'b0;
                        done_nxt      = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rv_burst_source.sv
// tb_rv_burst_source: directed bench for rv_burst_source.
// Ports: none (top-level bench).
module tb_rv_burst_source;

    logic       clk;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_base;
    logic [7:0] cmd_step;
    logic [7:0] cmd_len;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    rv_burst_source #(
        .DATA_WIDTH(8),
        .LEN_WIDTH (8)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_base (cmd_base),
        .cmd_step (cmd_step),
        .cmd_len  (cmd_len),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one command in IDLE; returns one cycle after acceptance.
    task automatic send_cmd(input logic [7:0] base, input logic [7:0] step, input logic [7:0] len);
        cmd_base  = base;
        cmd_step  = step;
        cmd_len   = len;
        cmd_valid = 1'b1;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Drain a burst. mode 0: always ready, 1: ready 1010..., 2: random ready.
    // Junk commands are offered throughout and must be ignored.
    // Returns at the cycle after the final handshake (done expected high).
    task automatic recv(input logic [7:0] base, input logic [7:0] step, input int len, input int mode);
        int         idx;
        int         cyc;
        logic [7:0] exp_data;
        idx = 0;
        cyc = 0;
        while (idx < len && cyc < 200) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            cmd_valid = 1'b1;
            cmd_base  = 8'($urandom);
            cmd_step  = 8'($urandom);
            cmd_len   = 8'($urandom_range(1, 255));
            exp_data  = 8'(base + 8'(idx) * step);
            chk("beat_valid", 32'(out_valid), 32'd1);
            chk("beat_data",  32'(out_data),  32'(exp_data));
            chk("beat_last",  32'(out_last),  32'(idx == len - 1));
            chk("beat_busy",  32'(busy),      32'd1);
            chk("beat_done",  32'(done),      32'd0);
            chk("beat_cmd_ready", 32'(cmd_ready), 32'd0);
            if (out_ready) idx++;
            tick();
            cyc++;
        end
        cmd_valid = 1'b0;
        out_ready = 1'b0;
        chk("burst_beats", 32'(idx), 32'(len));
        chk("end_valid", 32'(out_valid), 32'd0);
        chk("end_last",  32'(out_last),  32'd0);
        chk("end_done",  32'(done),      32'd1);
        chk("end_busy",  32'(busy),      32'd0);
        chk("end_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_base  = '0;
        cmd_step  = '0;
        cmd_len   = '0;
        out_ready = 1'b0;

        // 1: reset state
        #12;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_valid",     32'(out_valid), 32'd0);
        chk("rst_data",      32'(out_data),  32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // 2: 0x10,+1,4 at full throughput; first beat one cycle after accept
        send_cmd(8'h10, 8'h01, 8'd4);
        chk("t2_first_data", 32'(out_data), 32'h10);
        recv(8'h10, 8'h01, 4, 0);
        tick();
        chk("t2_done_width", 32'(done), 32'd0);
        chk("t2_idle_valid", 32'(out_valid), 32'd0);

        // 3: same command under 1010 and random backpressure
        send_cmd(8'h10, 8'h01, 8'd4);
        recv(8'h10, 8'h01, 4, 1);
        tick();
        send_cmd(8'h10, 8'h01, 8'd4);
        recv(8'h10, 8'h01, 4, 2);
        tick();

        // 4: wrap FE,01,04 then single beat
        send_cmd(8'hFE, 8'h03, 8'd3);
        chk("t4_beat0", 32'(out_data), 32'hFE);
        out_ready = 1'b1;
        tick();
        chk("t4_beat1", 32'(out_data), 32'h01);
        tick();
        chk("t4_beat2", 32'(out_data), 32'h04);
        chk("t4_last2", 32'(out_last), 32'd1);
        tick();
        out_ready = 1'b0;
        chk("t4_done", 32'(done), 32'd1);
        tick();
        send_cmd(8'h77, 8'h05, 8'd1);
        chk("t4_single_last", 32'(out_last), 32'd1);
        recv(8'h77, 8'h05, 1, 0);
        tick();

        // 5: empty burst
        send_cmd(8'h55, 8'h01, 8'd0);
        chk("t5_empty_valid", 32'(out_valid), 32'd0);
        chk("t5_empty_done",  32'(done),      32'd1);
        chk("t5_empty_busy",  32'(busy),      32'd0);
        tick();
        chk("t5_empty_done_off", 32'(done), 32'd0);
        chk("t5_empty_valid2",   32'(out_valid), 32'd0);

        // 5: back-to-back bursts with exactly one idle bubble
        send_cmd(8'h40, 8'h10, 8'd2);
        recv(8'h40, 8'h10, 2, 0);
        send_cmd(8'hA0, 8'hFF, 8'd3);
        chk("t5_b2b_done_off", 32'(done), 32'd0);
        recv(8'hA0, 8'hFF, 3, 0);
        tick();

        // 6: asynchronous reset mid-burst
        send_cmd(8'h20, 8'h02, 8'd5);
        out_ready = 1'b1;
        tick();
        tick();
        chk("t6_pre_rst_data", 32'(out_data), 32'h24);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid",     32'(out_valid), 32'd0);
        chk("t6_rst_data",      32'(out_data),  32'd0);
        chk("t6_rst_last",      32'(out_last),  32'd0);
        chk("t6_rst_busy",      32'(busy),      32'd0);
        chk("t6_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        out_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("t6_post_valid", 32'(out_valid), 32'd0);
        chk("t6_post_done",  32'(done),      32'd0);
        send_cmd(8'h30, 8'h05, 8'd3);
        recv(8'h30, 8'h05, 3, 0);
        tick();
        chk("t6_final_done", 32'(done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
